// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM states and address-field helpers for the two-way cache controller.
package cache_pkg;
    localparam int TAG_W  = 5;
    localparam int IDX_W  = 3;
    localparam int WORD_W = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = TAG_W + IDX_W + WORD_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return a[WORD_W +: IDX_W];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[WORD_W-1:0];
    endfunction
endpackage

// File: rtl/cache_lru.sv
// cache_lru: one LRU bit per set; the bit names the way to evict next when both ways are valid.
module cache_lru
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_upd,
    input  logic             i_val,
    output logic             o_lru
);
    logic [(1<<IDX_W)-1:0] r_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_bits <= '0;
        else if (i_upd) r_bits[i_idx] <= i_val;
    end

    assign o_lru = r_bits[i_idx];
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: two-way set-associative cache sequencer (lookup, victim select, write-back, refill, replay).
// Each way/memory access is a two-phase sub-step (issue, wait) so enables drop for a cycle between accesses.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_wr,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ready,
    output logic [1:0]        o_way_en,
    output logic              o_way_cmp,
    output logic              o_way_write,
    output logic              o_way_valid_in,
    output logic [IDX_W-1:0]  o_way_idx,
    output logic [TAG_W-1:0]  o_way_tag,
    output logic [WORD_W-1:0] o_way_word,
    output logic [DATA_W-1:0] o_way_data,
    input  logic [1:0]        i_way_hit,
    input  logic [1:0]        i_way_dirty,
    input  logic [1:0]        i_way_valid,
    input  logic [1:0]        i_way_ack,
    input  logic [TAG_W-1:0]  i_way_tag_out0,
    input  logic [TAG_W-1:0]  i_way_tag_out1,
    input  logic [DATA_W-1:0] i_way_data_out0,
    input  logic [DATA_W-1:0] i_way_data_out1,
    output logic              o_mem_req,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);
    state_t            r_state;
    logic [1:0]        r_ph, r_wen, r_ack, r_hit, r_vld, r_dty;
    logic [WORD_W-1:0] r_cnt, r_word;
    logic              r_wr, r_vic, r_mreq, r_refill;
    logic [TAG_W-1:0]  r_tag, r_vtag, r_tout0, r_tout1;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata, r_buf, r_dout0, r_dout1;
    logic [1:0]        w_ack, w_hit, w_vld, w_dty, w_vic_oh;
    logic [TAG_W-1:0]  w_tag0, w_tag1;
    logic [DATA_W-1:0] w_dat0, w_dat1;
    logic              w_lru, w_vic, w_vic_dirty, w_done, w_upd;

    // Ways may ack in different cycles: merge live status with what earlier acks left behind.
    assign w_ack       = r_ack | (i_way_ack & r_wen);
    assign w_hit       = (i_way_ack & i_way_hit) | (~i_way_ack & r_hit);
    assign w_vld       = (i_way_ack & i_way_valid) | (~i_way_ack & r_vld);
    assign w_dty       = (i_way_ack & i_way_dirty) | (~i_way_ack & r_dty);
    assign w_tag0      = i_way_ack[0] ? i_way_tag_out0 : r_tout0;
    assign w_tag1      = i_way_ack[1] ? i_way_tag_out1 : r_tout1;
    assign w_dat0      = i_way_ack[0] ? i_way_data_out0 : r_dout0;
    assign w_dat1      = i_way_ack[1] ? i_way_data_out1 : r_dout1;
    assign w_done      = (r_state == S_LOOKUP) && (r_ph == 2'd1) && (w_ack == 2'b11);
    assign w_vic       = !w_vld[0] ? 1'b0 : !w_vld[1] ? 1'b1 : w_lru;
    assign w_vic_dirty = w_vic ? (w_vld[1] & w_dty[1]) : (w_vld[0] & w_dty[0]);
    assign w_vic_oh    = r_vic ? 2'b10 : 2'b01;
    assign w_upd       = w_done && |w_hit;

    cache_lru u_lru (
        .clk   (clk),
        .rst   (rst),
        .i_idx (r_idx),
        .i_upd (w_upd),
        .i_val (w_hit[0]),
        .o_lru (w_lru)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ph <= '0; r_wen <= '0; r_ack <= '0; r_hit <= '0; r_vld <= '0; r_dty <= '0;
            r_cnt <= '0; r_word <= '0; r_wr <= 1'b0; r_vic <= 1'b0; r_mreq <= 1'b0; r_refill <= 1'b0;
            r_tag <= '0; r_vtag <= '0; r_tout0 <= '0; r_tout1 <= '0; r_idx <= '0;
            r_wdata <= '0; r_buf <= '0; r_dout0 <= '0; r_dout1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_cpu_req) begin
                    r_tag    <= addr_tag(i_cpu_addr);
                    r_idx    <= addr_idx(i_cpu_addr);
                    r_word   <= addr_word(i_cpu_addr);
                    r_wr     <= i_cpu_wr;
                    r_wdata  <= i_cpu_wdata;
                    r_refill <= 1'b0;
                    r_ph     <= 2'd0;
                    r_state  <= S_LOOKUP;
                end
                S_LOOKUP: if (r_ph == 2'd0) begin
                    r_wen <= 2'b11;
                    r_ph  <= 2'd1;
                end else begin
                    r_ack <= w_ack; r_hit <= w_hit; r_vld <= w_vld; r_dty <= w_dty;
                    r_tout0 <= w_tag0; r_tout1 <= w_tag1; r_dout0 <= w_dat0; r_dout1 <= w_dat1;
                    if (w_ack == 2'b11) begin
                        r_wen <= '0;
                        r_ack <= '0;
                        r_ph  <= 2'd0;
                        // A replay that still misses answers anyway rather than refilling twice.
                        if (|w_hit || r_refill) begin
                            r_buf   <= (r_wr || !(|w_hit)) ? '0 : (w_hit[0] ? w_dat0 : w_dat1);
                            r_state <= S_RESP;
                        end else begin
                            r_vic   <= w_vic;
                            r_vtag  <= w_vic ? w_tag1 : w_tag0;
                            r_state <= w_vic_dirty ? S_WB : S_FILL;
                        end
                    end
                end
                S_WB: case (r_ph)
                    2'd0: begin r_wen <= w_vic_oh; r_ph <= 2'd1; end
                    2'd1: if (|(i_way_ack & r_wen)) begin
                        r_buf <= r_vic ? i_way_data_out1 : i_way_data_out0;
                        r_wen <= '0;
                        r_ph  <= 2'd2;
                    end
                    2'd2: begin r_mreq <= 1'b1; r_ph <= 2'd3; end
                    default: if (i_mem_ack) begin
                        r_mreq  <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                        r_ph    <= 2'd0;
                        r_state <= &r_cnt ? S_FILL : S_WB;
                    end
                endcase
                S_FILL: case (r_ph)
                    2'd0: begin r_mreq <= 1'b1; r_ph <= 2'd1; end
                    2'd1: if (i_mem_ack) begin
                        r_buf  <= i_mem_rdata;
                        r_mreq <= 1'b0;
                        r_ph   <= 2'd2;
                    end
                    2'd2: begin r_wen <= w_vic_oh; r_ph <= 2'd3; end
                    default: if (|(i_way_ack & r_wen)) begin
                        r_wen    <= '0;
                        r_cnt    <= r_cnt + 1'b1;
                        r_ph     <= 2'd0;
                        r_refill <= &r_cnt;
                        r_state  <= &r_cnt ? S_LOOKUP : S_FILL;
                    end
                endcase
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_ready    = r_state == S_RESP;
    assign o_cpu_rdata    = o_cpu_ready ? r_buf : '0;
    assign o_way_en       = r_wen;
    assign o_way_cmp      = r_state == S_LOOKUP;
    assign o_way_write    = (r_state == S_LOOKUP && r_wr) || r_state == S_FILL;
    assign o_way_valid_in = r_state == S_FILL;
    assign o_way_idx      = r_idx;
    assign o_way_tag      = r_tag;
    assign o_way_word     = r_state == S_LOOKUP ? r_word : r_cnt;
    assign o_way_data     = r_state == S_LOOKUP ? r_wdata : r_state == S_FILL ? r_buf : '0;
    assign o_mem_req      = r_mreq;
    assign o_mem_wr       = r_state == S_WB;
    assign o_mem_addr     = {r_state == S_WB ? r_vtag : r_tag, r_idx, r_cnt};
    assign o_mem_wdata    = r_state == S_WB ? r_buf : '0;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized requests against a flat golden memory plus a set/way/LRU cache model.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic cpu_ready;
    logic [1:0] way_en;
    logic way_cmp, way_write, way_valid_in;
    logic [IDX_W-1:0] way_idx;
    logic [TAG_W-1:0] way_tag;
    logic [WORD_W-1:0] way_word;
    logic [DATA_W-1:0] way_data;
    logic [1:0] way_hit = '0, way_dirty = '0, way_valid = '0, way_ack = '0;
    logic [TAG_W-1:0] way_tag_out0 = '0, way_tag_out1 = '0;
    logic [DATA_W-1:0] way_data_out0 = '0, way_data_out1 = '0;
    logic mem_req, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic mem_ack = 1'b0;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
        .o_way_en(way_en), .o_way_cmp(way_cmp), .o_way_write(way_write), .o_way_valid_in(way_valid_in),
        .o_way_idx(way_idx), .o_way_tag(way_tag), .o_way_word(way_word), .o_way_data(way_data),
        .i_way_hit(way_hit), .i_way_dirty(way_dirty), .i_way_valid(way_valid), .i_way_ack(way_ack),
        .i_way_tag_out0(way_tag_out0), .i_way_tag_out1(way_tag_out1),
        .i_way_data_out0(way_data_out0), .i_way_data_out1(way_data_out1),
        .o_mem_req(mem_req), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural ways and backing memory that answer the controller.
    bit m_val[2][8], m_dty[2][8];
    logic [TAG_W-1:0] m_tag[2][8];
    logic [DATA_W-1:0] m_dat[2][8][4];
    logic [DATA_W-1:0] mem[1<<ADDR_W], gold[1<<ADDR_W];
    int w_dly[2];
    bit w_done[2];
    int last_ack = 0, last_fill = -1, n_mr = 0, n_mw = 0, n_ready = 0, n_req = 0;

    task automatic way_op(input int i);
        bit hit;
        hit = way_cmp && m_val[i][way_idx] && m_tag[i][way_idx] == way_tag;
        if (way_cmp) check("dual_hit", 32'(hit && m_val[1-i][way_idx] && m_tag[1-i][way_idx] == way_tag), 0);
        way_hit[i] = hit;
        way_valid[i] = m_val[i][way_idx];
        way_dirty[i] = m_dty[i][way_idx];
        if (i == 0) begin
            way_tag_out0 = m_tag[0][way_idx]; way_data_out0 = m_dat[0][way_idx][way_word];
        end else begin
            way_tag_out1 = m_tag[1][way_idx]; way_data_out1 = m_dat[1][way_idx][way_word];
        end
        if (way_cmp && hit && way_write) begin
            m_dat[i][way_idx][way_word] = way_data;
            m_dty[i][way_idx] = 1'b1;
        end
        if (!way_cmp && way_write) begin
            m_dat[i][way_idx][way_word] = way_data;
            m_tag[i][way_idx] = way_tag;
            m_val[i][way_idx] = way_valid_in;
            m_dty[i][way_idx] = 1'b0;
            last_fill = i;
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            way_ack[i] = 1'b0;
            if (!way_en[i] || rst) begin
                w_done[i] = 1'b0;
                w_dly[i] = $urandom_range(0, 2);
            end else if (!w_done[i]) begin
                if (w_dly[i] > 0) w_dly[i]--;
                else begin
                    way_op(i);
                    way_ack[i] = 1'b1;
                    w_done[i] = 1'b1;
                    last_ack = cyc;
                end
            end
        end
    end

    initial begin
        int mdly;
        bit mdone, prev;
        mdly = 0; mdone = 0;
        forever begin
            @(negedge clk);
            prev = mem_ack;
            mem_ack = 1'b0;
            if (prev) check("mem_req_drop", 32'(mem_req), 0);
            if (!mem_req || rst) begin
                mdone = 0;
                mdly = $urandom_range(0, 2);
            end else if (!mdone) begin
                if (mdly > 0) mdly--;
                else begin
                    if (mem_wr) begin
                        check("wb_data", 32'(mem_wdata), 32'(gold[mem_addr]));
                        mem[mem_addr] = mem_wdata;
                        n_mw++;
                    end else begin
                        mem_rdata = mem[mem_addr];
                        n_mr++;
                    end
                    mem_ack = 1'b1;
                    mdone = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cpu_ready) n_ready++;
    end

    // Reference cache: which line lives where, and the per-set LRU choice.
    bit c_val[8][2], c_dty[8][2], c_lru[8];
    logic [TAG_W-1:0] c_tag[8][2];

    function automatic logic [ADDR_W-1:0] mk(input int t, input int s, input int w);
        return {TAG_W'(t), IDX_W'(s), WORD_W'(w)};
    endfunction

    task automatic predict(input bit wr, input logic [ADDR_W-1:0] a, output bit hit, output int vic, output int nwb);
        int s;
        logic [TAG_W-1:0] t;
        t = addr_tag(a);
        s = int'(addr_idx(a));
        hit = 0; vic = 0; nwb = 0;
        for (int w = 0; w < 2; w++)
            if (c_val[s][w] && c_tag[s][w] == t) begin hit = 1; vic = w; end
        if (hit) begin
            if (wr) c_dty[s][vic] = 1;
        end else begin
            vic = !c_val[s][0] ? 0 : !c_val[s][1] ? 1 : int'(c_lru[s]);
            nwb = (c_val[s][vic] && c_dty[s][vic]) ? 4 : 0;
            c_val[s][vic] = 1; c_tag[s][vic] = t; c_dty[s][vic] = wr;
        end
        c_lru[s] = (vic == 0);
    endtask

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit spur);
        bit hit, got, pulsed;
        int vic, nwb, lat;
        logic [DATA_W-1:0] exp_rd, rd;
        predict(wr, a, hit, vic, nwb);
        exp_rd = wr ? '0 : gold[a];
        if (wr) gold[a] = d;
        n_mr = 0; n_mw = 0; last_fill = -1;
        got = 0; pulsed = 0; lat = 0; rd = '0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        for (int k = 0; k < 600 && !got; k++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1; cpu_req = 1'b0; rd = cpu_rdata; lat = cyc - last_ack;
            end else begin
                cpu_req = spur && !pulsed && mem_req && !mem_wr;
                if (cpu_req) begin
                    pulsed = 1; cpu_wr = 1'b1; cpu_addr = ADDR_W'($urandom);
                end
            end
        end
        n_req++;
        check("ready_timeout", 32'(got), 1);
        if (got) begin
            check("rdata", 32'(rd), 32'(exp_rd));
            check("mem_reads", n_mr, hit ? 0 : 4);
            check("mem_writes", n_mw, nwb);
            if (!hit) check("fill_way", last_fill, vic);
            else check("hit_latency_le2", 32'(lat <= 2), 1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            mem[a] = DATA_W'($urandom);
            gold[a] = mem[a];
        end
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 8; s++) begin
                m_val[i][s] = 0; m_dty[i][s] = 0; m_tag[i][s] = '0;
                c_val[s][i] = 0; c_dty[s][i] = 0; c_tag[s][i] = '0; c_lru[s] = 0;
                for (int w = 0; w < 4; w++) m_dat[i][s][w] = '0;
            end
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 0);
        check("rst_rdata", 32'(cpu_rdata), 0);
        check("rst_way_en", 32'(way_en), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;

        do_req(0, mk(3, 0, 3), '0, 0);
        do_req(0, mk(3, 0, 3), '0, 0);
        do_req(1, mk(3, 0, 1), 16'hF0F0, 0);
        do_req(0, mk(5, 0, 2), '0, 1);
        do_req(0, mk(7, 0, 0), '0, 0);
        check("wb_word1_in_mem", 32'(mem[mk(3, 0, 1)]), 32'hF0F0);
        do_req(0, mk(9, 0, 1), '0, 0);
        do_req(0, mk(7, 0, 2), '0, 0);

        // Abort a write-back part-way through with reset.
        do_req(1, mk(1, 2, 0), 16'h1234, 0);
        do_req(1, mk(2, 2, 1), 16'h5678, 0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = mk(3, 2, 2);
        @(negedge clk);
        cpu_req = 1'b0;
        found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (mem_req && mem_wr && mem_addr[WORD_W-1:0] == 2'd2) found = 1;
            else @(negedge clk);
        end
        check("wb_word2_reached", 32'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_way_en", 32'(way_en), 0);
        check("abort_ready", 32'(cpu_ready), 0);
        check("abort_state_idle", 32'(dut.r_state), 32'(S_IDLE));
        check("abort_lru_clear", 32'(dut.u_lru.r_bits), 0);
        for (int s = 0; s < 8; s++) c_lru[s] = 0;
        @(negedge clk);
        rst = 1'b0;
        do_req(0, mk(1, 2, 0), '0, 0);
        do_req(0, mk(4, 2, 3), '0, 0);

        for (int n = 0; n < 140; n++)
            do_req($urandom_range(0, 9) < 4, mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3)),
                   DATA_W'($urandom), $urandom_range(0, 3) == 0);

        repeat (4) @(negedge clk);
        check("ready_count", n_ready, n_req);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
